// File: rtl/vrf_wb_arbiter_if.sv
// Writeback bus between the ALU / load-unit requesters, the decode stage and
// the vector register-file arbiter. Requesters and decode drive through the
// master modport; the arbiter sits on the slave modport.
interface vrf_wb_arbiter_if #(
  parameter int N     = 16,  // lane width in bits
  parameter int LANES = 16   // lanes per vector register
);

  // ALU writeback request channel
  logic                       alu_valid;
  logic [3:0]                 alu_wa;
  logic [LANES-1:0][N-1:0]    alu_wd;
  logic                       alu_ready;

  // Load-unit writeback request channel
  logic                       mem_valid;
  logic [3:0]                 mem_wa;
  logic [LANES-1:0][N-1:0]    mem_wd;
  logic                       mem_ready;

  // Decode-stage read addresses and stall feedback
  logic [3:0]                 ra1;
  logic [3:0]                 ra2;
  logic                       stall_d;

  // Register-file write port
  logic                       RegWriteW;
  logic [3:0]                 wa3w;
  logic [LANES-1:0][N-1:0]    wd3;

  modport master (
    output alu_valid, alu_wa, alu_wd,
    output mem_valid, mem_wa, mem_wd,
    output ra1, ra2,
    input  alu_ready, mem_ready,
    input  RegWriteW, wa3w, wd3,
    input  stall_d
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd,
    input  mem_valid, mem_wa, mem_wd,
    input  ra1, ra2,
    output alu_ready, mem_ready,
    output RegWriteW, wa3w, wd3,
    output stall_d
  );

endinterface

// File: rtl/vrf_wb_arbiter.sv
// Two-requester (ALU / load unit) writeback arbiter for the vector register file.
// Latency: one cycle from transfer to RegWriteW/wa3w/wd3; one write per cycle.
// Backpressure: valid/ready, loser held off until granted; WB_ROUND_ROBIN_EN enables
// the alternating priority pointer, otherwise the ALU always wins ties.
module vrf_wb_arbiter #(
  parameter int N     = 16,
  parameter int LANES = 16
) (
  input  logic              clk,
  input  logic              RST,
  vrf_wb_arbiter_if.slave   bus
);

  typedef logic [LANES-1:0][N-1:0] vec_t;

  // Register 15 is the "no register" encoding and never creates a hazard.
  localparam logic [3:0] NO_REG = 4'hF;

  logic       alu_gnt;
  logic       mem_gnt;
  logic       prio_mem;      // 1: load unit wins when both request

  logic       reg_we_q, reg_we_d;
  logic [3:0] wa_q,     wa_d;
  vec_t       wd_q,     wd_d;

  logic       hit_ra1;
  logic       hit_ra2;

`ifdef WB_ROUND_ROBIN_EN
  logic ptr_q, ptr_d;

  // Pointer moves to whichever requester was not granted; idle cycles hold it.
  always_comb begin
    ptr_d = ptr_q;
    if (alu_gnt) begin
      ptr_d = 1'b1;
    end else if (mem_gnt) begin
      ptr_d = 1'b0;
    end
  end

  // Priority pointer register, ALU preferred out of reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign prio_mem = ptr_q;
`else
  // Fixed priority: ALU always wins a tie.
  assign prio_mem = 1'b0;
`endif

  // Grant decode: a lone requester always wins, ties go to the pointer.
  // Nothing is granted while reset is held, so no transfer can occur then.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (!RST) begin
      alu_gnt = bus.alu_valid && (!bus.mem_valid || !prio_mem);
      mem_gnt = bus.mem_valid && (!bus.alu_valid ||  prio_mem);
    end
  end

  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;

  // Next write-port contents: winner's address/data; address/data hold when idle.
  always_comb begin
    reg_we_d = 1'b0;
    wa_d     = wa_q;
    wd_d     = wd_q;
    if (alu_gnt) begin
      reg_we_d = 1'b1;
      wa_d     = bus.alu_wa;
      wd_d     = bus.alu_wd;
    end else if (mem_gnt) begin
      reg_we_d = 1'b1;
      wa_d     = bus.mem_wa;
      wd_d     = bus.mem_wd;
    end
  end

  // Write-port register; reset also kills any write that was about to issue.
  always_ff @(posedge clk) begin
    if (RST) begin
      reg_we_q <= 1'b0;
      wa_q     <= 4'd0;
      wd_q     <= '0;
    end else begin
      reg_we_q <= reg_we_d;
      wa_q     <= wa_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.RegWriteW = reg_we_q;
  assign bus.wa3w      = wa_q;
  assign bus.wd3       = wd_q;

  // Read-after-write hazard: a decode source matches any pending or in-flight
  // destination. Pending requests count whether or not they win this cycle,
  // since the loser's value is still on its way to the file.
  always_comb begin
    hit_ra1 = 1'b0;
    hit_ra2 = 1'b0;
    if (bus.ra1 != NO_REG) begin
      hit_ra1 = (bus.alu_valid && (bus.ra1 == bus.alu_wa)) ||
                (bus.mem_valid && (bus.ra1 == bus.mem_wa)) ||
                (reg_we_q      && (bus.ra1 == wa_q));
    end
    if (bus.ra2 != NO_REG) begin
      hit_ra2 = (bus.alu_valid && (bus.ra2 == bus.alu_wa)) ||
                (bus.mem_valid && (bus.ra2 == bus.mem_wa)) ||
                (reg_we_q      && (bus.ra2 == wa_q));
    end
  end

  assign bus.stall_d = !RST && (hit_ra1 || hit_ra2);

  // At most one requester may be accepted in any cycle.
  a_one_ready: assert property (@(posedge clk) !(alu_gnt && mem_gnt));

  // A write can only appear one cycle after a grant.
  a_we_follows_gnt: assert property (@(posedge clk) disable iff (RST)
                                     (alu_gnt || mem_gnt) |=> reg_we_q);

endmodule

// File: tb/tb_vrf_wb_arbiter.sv
// Directed self-checking bench for vrf_wb_arbiter: reset, single request,
// contention (round-robin or fixed priority by WB_ROUND_ROBIN_EN), hazards, mid-stream reset.
module tb_vrf_wb_arbiter;

  localparam int N     = 16;
  localparam int LANES = 16;
  localparam int W     = N * LANES;

  logic clk;
  logic RST;

  int checks   = 0;
  int failures = 0;

  vrf_wb_arbiter_if #(.N(N), .LANES(LANES)) bus ();

  vrf_wb_arbiter #(.N(N), .LANES(LANES)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] d_a5, d_alu, d_mem;
  logic         exp_alu;

  initial begin
    d_a5  = {LANES{16'h00A5}};
    d_alu = {LANES{16'h1111}};
    d_mem = {LANES{16'h2222}};

    // Reset held two cycles with both requesters asserting.
    RST           = 1'b1;
    bus.alu_valid = 1'b1;
    bus.alu_wa    = 4'd1;
    bus.alu_wd    = d_alu;
    bus.mem_valid = 1'b1;
    bus.mem_wa    = 4'd2;
    bus.mem_wd    = d_mem;
    bus.ra1       = 4'd1;
    bus.ra2       = 4'd2;
    #1;
    chk("rst_alu_ready", W'(bus.alu_ready), W'(0));
    chk("rst_mem_ready", W'(bus.mem_ready), W'(0));
    chk("rst_stall",     W'(bus.stall_d),   W'(0));
    tick();
    tick();
    chk("rst_we",     W'(bus.RegWriteW), W'(0));
    chk("rst_wa3w",   W'(bus.wa3w),      W'(0));
    chk("rst_wd3",    bus.wd3,           W'(0));
    chk("rst_ready2", W'({bus.alu_ready, bus.mem_ready}), W'(0));

    // Release reset with nothing requesting.
    RST           = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.ra1       = 4'd15;
    bus.ra2       = 4'd15;
    #1;
    chk("idle_ready", W'({bus.alu_ready, bus.mem_ready}), W'(0));
    tick();
    chk("idle_we", W'(bus.RegWriteW), W'(0));

    // Single ALU request, one cycle.
    bus.alu_valid = 1'b1;
    bus.alu_wa    = 4'd3;
    bus.alu_wd    = d_a5;
    #1;
    chk("single_alu_ready", W'(bus.alu_ready), W'(1));
    chk("single_mem_ready", W'(bus.mem_ready), W'(0));
    tick();
    bus.alu_valid = 1'b0;
    chk("single_we",   W'(bus.RegWriteW), W'(1));
    chk("single_wa3w", W'(bus.wa3w),      W'(3));
    chk("single_wd3",  bus.wd3,           d_a5);
    tick();
    chk("single_we_drop", W'(bus.RegWriteW), W'(0));
    chk("single_wa_hold", W'(bus.wa3w),      W'(3));
    chk("single_wd_hold", bus.wd3,           d_a5);

    // Hazards: register 15 never stalls; a pending load to 5 stalls ra2 = 5.
    bus.mem_valid = 1'b1;
    bus.mem_wa    = 4'd15;
    bus.mem_wd    = d_mem;
    #1;
    chk("haz_r15", W'(bus.stall_d), W'(0));
    bus.mem_wa = 4'd5;
    bus.ra2    = 4'd5;
    #1;
    chk("haz_pending", W'(bus.stall_d),   W'(1));
    chk("haz_mem_rdy", W'(bus.mem_ready), W'(1));
    tick();
    bus.mem_valid = 1'b0;
    bus.ra2       = 4'd15;
    bus.ra1       = 4'd3;   // matches alu_wa, but ALU is not requesting
    #1;
    chk("haz_stale_alu_wa", W'(bus.stall_d), W'(0));
    bus.ra1 = 4'd5;
    #1;
    chk("haz_inflight_we", W'(bus.RegWriteW), W'(1));
    chk("haz_inflight_wa", W'(bus.wa3w),      W'(5));
    chk("haz_inflight",    W'(bus.stall_d),   W'(1));
    tick();
    chk("haz_cleared", W'(bus.stall_d), W'(0));
    bus.ra1 = 4'd15;

    // Contention: both requesters keep asserting for four cycles.
    // The last lone grant was to the load unit, so the pointer prefers the ALU.
    bus.alu_valid = 1'b1;
    bus.alu_wa    = 4'd1;
    bus.alu_wd    = d_alu;
    bus.mem_valid = 1'b1;
    bus.mem_wa    = 4'd2;
    bus.mem_wd    = d_mem;
    for (int i = 0; i < 4; i++) begin
`ifdef WB_ROUND_ROBIN_EN
      exp_alu = (i % 2) == 0;
`else
      exp_alu = 1'b1;
`endif
      #1;
      chk($sformatf("cont%0d_alu_ready", i), W'(bus.alu_ready), W'(exp_alu));
      chk($sformatf("cont%0d_mem_ready", i), W'(bus.mem_ready), W'(!exp_alu));
      tick();
      chk($sformatf("cont%0d_we", i),   W'(bus.RegWriteW), W'(1));
      chk($sformatf("cont%0d_wa3w", i), W'(bus.wa3w),      exp_alu ? W'(1) : W'(2));
      chk($sformatf("cont%0d_wd3", i),  bus.wd3,           exp_alu ? d_alu : d_mem);
    end
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    tick();
    chk("cont_end_we", W'(bus.RegWriteW), W'(0));

    // Mid-stream reset: an ALU transfer moves the pointer toward the load unit,
    // then reset lands while the ALU re-presents a request.
    bus.alu_valid = 1'b1;
    bus.alu_wa    = 4'd7;
    tick();
    chk("mid_pre_we", W'(bus.RegWriteW), W'(1));
    RST    = 1'b1;
    bus.ra1 = 4'd7;
    #1;
    chk("mid_rst_ready", W'(bus.alu_ready), W'(0));
    chk("mid_rst_stall", W'(bus.stall_d),   W'(0));
    tick();
    chk("mid_rst_we",   W'(bus.RegWriteW), W'(0));
    chk("mid_rst_wa3w", W'(bus.wa3w),      W'(0));
    // Pointer must be back at ALU-preferred: a tie goes to the ALU.
    RST           = 1'b0;
    bus.ra1       = 4'd15;
    bus.alu_wa    = 4'd1;
    bus.mem_valid = 1'b1;
    #1;
    chk("mid_ptr_alu", W'(bus.alu_ready), W'(1));
    chk("mid_ptr_mem", W'(bus.mem_ready), W'(0));
    tick();
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    chk("mid_post_we",   W'(bus.RegWriteW), W'(1));
    chk("mid_post_wa3w", W'(bus.wa3w),      W'(1));
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
